// File: rtl/sdram_ctrl_module.sv
// sdram_ctrl_module
// Top-level sequencer for the SDRAM sub-modules. It runs the power-up init
// once. It then arbitrates between periodic auto-refresh and user write/read
// requests. It raises one start/hold line per sub-module and waits for that
// sub-module's one-cycle done pulse.
module sdram_ctrl_module #(
    parameter int unsigned      REF_W = 10,
    parameter logic [REF_W-1:0] T_REF = 10'd300
) (
    input  logic       CLK,
    input  logic       RSTn,
    output logic       Init_Start_Sig,
    input  logic       Init_Done_Sig,
    output logic [2:0] Func_Start_Sig,
    input  logic       Func_Done_Sig,
    input  logic       Wr_Req,
    input  logic       Rd_Req,
    output logic       Wr_Ack,
    output logic       Rd_Ack,
    output logic       Ready,
    output logic       Ref_Err
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_AREF,
        S_WRITE,
        S_READ
    } state_t;

    localparam logic [2:0] FUNC_AREF  = 3'b100;
    localparam logic [2:0] FUNC_READ  = 3'b010;
    localparam logic [2:0] FUNC_WRITE = 3'b001;

    localparam logic [REF_W-1:0] C_REF_LAST = T_REF - 1'b1;

    state_t           r_state;
    logic             r_init_start;
    logic [2:0]       r_func_start;
    logic             r_wr_ack;
    logic             r_rd_ack;
    logic             r_ready;
    logic             r_ref_err;
    logic             r_ref_pending;
    logic [REF_W-1:0] r_ref_cnt;
    logic             r_rr_wr;       // 1: write wins the next write/read tie

    logic w_wr_req;
    logic w_rd_req;
    logic w_ref_wrap;

    // A request that is still high during its own ack cycle belongs to the
    // transfer just acknowledged. It only counts as new from the next cycle.
    assign w_wr_req   = Wr_Req & ~r_wr_ack;
    assign w_rd_req   = Rd_Req & ~r_rd_ack;
    assign w_ref_wrap = r_ready && (r_ref_cnt == C_REF_LAST);

    // Sequencer FSM, arbiter and refresh timer; every output is a register.
    always_ff @(posedge CLK) begin
        // NOTE: reset is synchronous, so RSTn is only looked at on the clock edge.
        if (!RSTn) begin
            r_state       <= S_INIT;
            r_init_start  <= 1'b0;
            r_func_start  <= 3'b000;
            r_wr_ack      <= 1'b0;
            r_rd_ack      <= 1'b0;
            r_ready       <= 1'b0;
            r_ref_err     <= 1'b0;
            r_ref_pending <= 1'b0;
            r_ref_cnt     <= '0;
            r_rr_wr       <= 1'b1;
        end else begin
            r_wr_ack <= 1'b0;
            r_rd_ack <= 1'b0;

            case (r_state)
                S_INIT: begin
                    if (Init_Done_Sig) begin
                        r_init_start <= 1'b0;
                        r_ready      <= 1'b1;
                        r_ref_cnt    <= '0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_init_start <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (r_ref_pending) begin
                        r_ref_pending <= 1'b0;
                        r_func_start  <= FUNC_AREF;
                        r_state       <= S_AREF;
                    end else if (w_wr_req && (!w_rd_req || r_rr_wr)) begin
                        r_func_start <= FUNC_WRITE;
                        r_rr_wr      <= 1'b0;
                        r_state      <= S_WRITE;
                    end else if (w_rd_req) begin
                        r_func_start <= FUNC_READ;
                        r_rr_wr      <= 1'b1;
                        r_state      <= S_READ;
                    end
                end
                S_AREF, S_WRITE, S_READ: begin
                    if (Func_Done_Sig) begin
                        r_func_start <= 3'b000;
                        r_wr_ack     <= (r_state == S_WRITE);
                        r_rd_ack     <= (r_state == S_READ);
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_init_start <= 1'b0;
                    r_func_start <= 3'b000;
                    r_state      <= S_INIT;
                end
            endcase

            // NOTE: this comes after the arbiter on purpose. When a wrap lands
            // on the same edge as an AREF grant, the later write keeps the new
            // interval's refresh pending.
            if (r_ready) begin
                if (w_ref_wrap) begin
                    r_ref_cnt     <= '0;
                    r_ref_pending <= 1'b1;
                    if (r_ref_pending) begin
                        r_ref_err <= 1'b1;
                    end
                end else begin
                    r_ref_cnt <= r_ref_cnt + 1'b1;
                end
            end
        end
    end

    assign Init_Start_Sig = r_init_start;
    assign Func_Start_Sig = r_func_start;
    assign Wr_Ack         = r_wr_ack;
    assign Rd_Ack         = r_rd_ack;
    assign Ready          = r_ready;
    assign Ref_Err        = r_ref_err;

endmodule

// File: tb/tb_sdram_ctrl_module.sv
// tb_sdram_ctrl_module
// Directed bench for the SDRAM sequencer. Cycle n is the clock period after
// the n-th rising edge following the release of RSTn. Inputs are driven and
// outputs are sampled on the falling edge.
module tb_sdram_ctrl_module;

    logic       CLK;
    logic       RSTn;
    logic       Init_Start_Sig;
    logic       Init_Done_Sig;
    logic [2:0] Func_Start_Sig;
    logic       Func_Done_Sig;
    logic       Wr_Req;
    logic       Rd_Req;
    logic       Wr_Ack;
    logic       Rd_Ack;
    logic       Ready;
    logic       Ref_Err;

    int n_checks;
    int n_fail;
    int cyc;

    sdram_ctrl_module #(
        .REF_W (10),
        .T_REF (10'd300)
    ) dut (
        .CLK            (CLK),
        .RSTn           (RSTn),
        .Init_Start_Sig (Init_Start_Sig),
        .Init_Done_Sig  (Init_Done_Sig),
        .Func_Start_Sig (Func_Start_Sig),
        .Func_Done_Sig  (Func_Done_Sig),
        .Wr_Req         (Wr_Req),
        .Rd_Req         (Rd_Req),
        .Wr_Ack         (Wr_Ack),
        .Rd_Ack         (Rd_Ack),
        .Ready          (Ready),
        .Ref_Err        (Ref_Err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        cyc++;
    endtask

    // Checks an operation that has just started. It holds for 'hold' cycles,
    // returns done in the last of them, and then checks the stop and the ack
    // one cycle later. On return the bench sits in the ack cycle.
    task automatic op(input string tag, input logic [2:0] f, input int hold,
                      input logic exp_wr, input logic exp_rd);
        logic ok;
        ok = 1'b1;
        check({tag, "_start"}, Func_Start_Sig, f);
        for (int i = 1; i < hold; i++) begin
            tick();
            if (Func_Start_Sig !== f || Wr_Ack !== 1'b0 || Rd_Ack !== 1'b0) ok = 1'b0;
        end
        check({tag, "_held"}, ok, 1'b1);
        Func_Done_Sig = 1'b1;
        tick();
        Func_Done_Sig = 1'b0;
        check({tag, "_stop"}, Func_Start_Sig, 3'b000);
        check({tag, "_wr_ack"}, Wr_Ack, exp_wr);
        check({tag, "_rd_ack"}, Rd_Ack, exp_rd);
    endtask

    // Ticks until cycle 'last' and checks that no start or ack appears.
    task automatic quiet_until(input string tag, input int last);
        logic ok;
        ok = 1'b1;
        while (cyc < last) begin
            tick();
            if (Func_Start_Sig !== 3'b000 || Wr_Ack !== 1'b0 || Rd_Ack !== 1'b0) ok = 1'b0;
        end
        check(tag, ok, 1'b1);
    endtask

    initial begin
        logic ok;
        n_checks      = 0;
        n_fail        = 0;
        cyc           = 0;
        RSTn          = 1'b0;
        Init_Done_Sig = 1'b0;
        Func_Done_Sig = 1'b0;
        Wr_Req        = 1'b0;
        Rd_Req        = 1'b0;

        // Power-up: reset for 3 cycles, then init done pulsed in cycle 10.
        repeat (3) @(negedge CLK);
        check("rst_outputs", {Init_Start_Sig, Func_Start_Sig, Wr_Ack, Rd_Ack, Ready, Ref_Err}, 8'h00);
        RSTn = 1'b1;
        cyc  = 0;
        ok   = 1'b1;
        Wr_Req = 1'b1;                     // must be ignored in INIT
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (Init_Start_Sig !== 1'b1 || Ready !== 1'b0 || Func_Start_Sig !== 3'b000) ok = 1'b0;
        end
        check("init_hold_1_to_10", ok, 1'b1);
        Wr_Req        = 1'b0;
        Init_Done_Sig = 1'b1;
        tick();                            // cycle 11
        Init_Done_Sig = 1'b0;
        check("init_ready", Ready, 1'b1);
        check("init_start_off", Init_Start_Sig, 1'b0);
        check("init_no_func", Func_Start_Sig, 3'b000);

        // Single write: request in cycle 11, start in 12, held for 8 cycles.
        Wr_Req = 1'b1;
        tick();                            // cycle 12
        op("wr", 3'b001, 8, 1'b1, 1'b0);   // ack cycle 20
        Wr_Req = 1'b0;

        // Stray done pulses in IDLE must not do anything.
        Func_Done_Sig = 1'b1;
        Init_Done_Sig = 1'b1;
        tick();                            // cycle 21
        Func_Done_Sig = 1'b0;
        Init_Done_Sig = 1'b0;
        check("stray_done_ignored", {Init_Start_Sig, Func_Start_Sig, Wr_Ack, Rd_Ack, Ready}, 6'b000001);

        // Refresh: counter restarts at edge 11, wraps at edge 311, AREF at 312.
        quiet_until("idle_quiet_to_311", 311);
        tick();                            // cycle 312
        op("aref1", 3'b100, 3, 1'b0, 1'b0);  // ack cycle 315
        check("aref1_no_err", Ref_Err, 1'b0);

        // Single read; this also leaves write next in line for a tie.
        Rd_Req = 1'b1;
        tick();                            // cycle 316
        op("rd", 3'b010, 3, 1'b0, 1'b1);   // ack cycle 319
        Rd_Req = 1'b0;

        // Contention: both requests held, the next wrap (edge 611) lands
        // during the first write.
        quiet_until("idle_quiet_to_600", 600);
        Wr_Req = 1'b1;
        Rd_Req = 1'b1;
        tick();                            // cycle 601
        op("c_wr", 3'b001, 20, 1'b1, 1'b0);  // ack cycle 621
        tick();
        op("c_aref", 3'b100, 3, 1'b0, 1'b0); // ack cycle 625
        tick();
        op("c_rd", 3'b010, 4, 1'b0, 1'b1);   // ack cycle 630
        tick();
        op("c_wr2", 3'b001, 2, 1'b1, 1'b0);  // ack cycle 633
        tick();
        op("c_rd2", 3'b010, 2, 1'b0, 1'b1);  // ack cycle 636
        check("c_no_err", Ref_Err, 1'b0);
        Rd_Req = 1'b0;

        // Overrun: the write starting at 637 spans the wraps at 911 and 1211.
        tick();                            // cycle 637
        check("ovr_start", Func_Start_Sig, 3'b001);
        ok = 1'b1;
        while (cyc < 1210) begin
            tick();
            if (Func_Start_Sig !== 3'b001) ok = 1'b0;
        end
        check("ovr_held", ok, 1'b1);
        check("ovr_err_before", Ref_Err, 1'b0);
        tick();                            // cycle 1211
        check("ovr_err_set", Ref_Err, 1'b1);
        while (cyc < 1250) tick();
        Func_Done_Sig = 1'b1;
        tick();                            // cycle 1251
        Func_Done_Sig = 1'b0;
        check("ovr_wr_ack", Wr_Ack, 1'b1);
        Wr_Req = 1'b0;
        tick();                            // cycle 1252
        op("ovr_aref", 3'b100, 2, 1'b0, 1'b0); // ack cycle 1254
        check("err_sticky", Ref_Err, 1'b1);

        // Reset in the middle of a read.
        Rd_Req = 1'b1;
        tick();                            // cycle 1255
        check("mid_rd_start", Func_Start_Sig, 3'b010);
        RSTn = 1'b0;
        tick();                            // cycle 1256
        check("mid_rst_outputs", {Init_Start_Sig, Func_Start_Sig, Wr_Ack, Rd_Ack, Ready, Ref_Err}, 8'h00);
        RSTn   = 1'b1;
        Wr_Req = 1'b1;                     // both held through INIT
        tick();                            // cycle 1257
        check("reinit_start", {Init_Start_Sig, Func_Start_Sig, Ready}, 5'b10000);
        ok = 1'b1;
        repeat (2) begin
            tick();
            if (Func_Start_Sig !== 3'b000 || Init_Start_Sig !== 1'b1) ok = 1'b0;
        end
        check("reinit_reqs_ignored", ok, 1'b1);
        Init_Done_Sig = 1'b1;
        tick();
        Init_Done_Sig = 1'b0;
        check("reinit_ready", {Init_Start_Sig, Func_Start_Sig, Ready}, 5'b00001);
        tick();
        check("rr_after_reset_wr_first", Func_Start_Sig, 3'b001);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
